vxc_stream_ctrl: RTL and testbench
==================================

Name: vxc_stream_ctrl

Overview:
- Streaming controller placed directly upstream of the 8-lane vector-times-constant add/subtract unit.
- Reads two source vectors of NOE elements from row memories, NI elements per chunk, and presents each chunk with a latched constant and op to the arithmetic unit.
- Tracks the unit's fixed pipeline latency, writes each result chunk back to a result memory with padding lanes zeroed, and pulses finish when the whole vector is done.
- Replaces counter-guessing with an exact per-chunk valid pipeline.

Parameters:
NOE, 16, number of valid vector elements
NI, 8, lanes per chunk
element_width, 32, bits per element
LAT, 4, arithmetic unit latency in cycles from inputs presented to result valid
ADDR_W, 8, chunk address width; CHUNKS = ceil(NOE/NI) must be ≤ 2^ADDR_W

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  begin operation when idle
op_in  in  1  0 = add, 1 = subtract; latched at start
constant_in  in  element_width  scalar; latched at start
rd_en  out  1  row memory read strobe
rd_addr  out  ADDR_W  chunk index read
first_row_data  in  element_width*NI  first-row memory data, valid 1 cycle after rd_en
second_row_data  in  element_width*NI  second-row memory data, valid 1 cycle after rd_en
first_row_input  out  element_width*NI  to arithmetic unit
second_row_input  out  element_width*NI  to arithmetic unit
constant  out  element_width  to arithmetic unit (latched value)
op  out  1  to arithmetic unit (latched value)
result  in  element_width*NI  from arithmetic unit
wr_en  out  1  result memory write strobe
wr_addr  out  ADDR_W  chunk index written
wr_data  out  element_width*NI  result chunk, padding lanes zeroed
busy  out  1  high from the cycle after start is accepted through the finish cycle
finish  out  1  one-cycle completion pulse

Behaviour:
- Lane j of a chunk occupies bits [element_width*(NI-j)-1 -: element_width]; lane 0 is the MSBs.
- Element index for chunk k, lane j = k*NI + j.

Reset (reset = 0, asynchronous):
- All outputs go to 0: rd_en, wr_en, finish, busy, addresses, data, constant, op.
- FSM goes to IDLE; the valid pipeline clears.
- A reset mid-operation aborts it: no further writes and no finish pulse.

FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start = 1 latches constant_in and op_in, clears the read counter, and moves to ISSUE.
  - start in any other state is ignored.
- ISSUE:
  - rd_en = 1 with rd_addr = 0, 1, …, CHUNKS-1 on consecutive cycles.
  - After issuing CHUNKS-1, move to DRAIN.
- DRAIN:
  - Wait until the last chunk has been written, then move to DONE.
- DONE:
  - finish = 1 and busy = 1 for exactly this cycle.
  - Next state is IDLE. start is accepted again in the cycle after DONE.

Datapath timing, for a read issued in cycle t:
- t+1: memory data is valid and is registered into first_row_input / second_row_input.
- t+2: the unit inputs hold chunk k.
- t+2+LAT: result is valid. wr_en = 1, wr_addr = k, wr_data = result with lanes where k*NI+j ≥ NOE forced to 0.
- Other timing rules:
  - A valid/address shift register of depth 2+LAT carries k. Writes occur on consecutive cycles.
  - Unit inputs hold their last value when no read is returning. wr_data and wr_addr are don't-care when wr_en = 0.
  - The padding lanes of input chunks pass memory contents through unmodified; only the write data is masked.
- Total timing:
  - The first write is in cycle 2+LAT after the first rd_en.
  - The last write is in cycle CHUNKS+1+LAT.
  - The finish pulse is in the following cycle.

Boundary cases:
- NOE divisible by NI: no padding lanes, and no extra chunk is issued.
- CHUNKS = 1: ISSUE lasts one cycle.
- constant and op stay stable for the whole operation even if constant_in / op_in change.

Test Plan:
- NOE=16, NI=8, LAT=4; start in cycle 0, op_in=0, constant_in=0x40000000. Required response:
  - rd_en in cycles 1,2 with rd_addr 0,1.
  - wr_en in cycles 7,8 with wr_addr 0,1, and wr_data equal to the model result.
  - finish high only in cycle 9; busy high in cycles 1–9.
- NOE=20, NI=8: 3 chunks read. Chunk 2 write has lanes 4–7 equal to 0 and lanes 0–3 equal to the unit result. finish occurs exactly once.
- start pulsed again in cycle 4 with op_in=1 and a different constant: ignored. constant and op outputs keep the cycle-0 values, and no extra reads occur.
- reset driven to 0 in cycle 6 of the first scenario: all outputs become 0 asynchronously. No wr_en and no finish follow after release. A new start then runs a full correct sequence.
- Back-to-back runs: start asserted the cycle after finish is accepted. The second run's rd_en begins the next cycle with rd_addr 0, and there is no overlap of writes.
- LAT=1, NOE=8: a single chunk is read in cycle 1 and written in cycle 4, and finish occurs in cycle 5.

Source files
------------

// File: rtl/vxc_stream_ctrl.sv
// Streaming controller feeding the vector-times-constant unit: issues chunk reads, tracks the
// unit latency with a per-chunk valid/address pipeline and writes masked results back.
module vxc_stream_ctrl #(
  parameter int unsigned NOE           = 16,
  parameter int unsigned NI            = 8,
  parameter int unsigned element_width = 32,
  parameter int unsigned LAT           = 4,
  parameter int unsigned ADDR_W        = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          op_in,
  input  logic [element_width-1:0]      constant_in,
  output logic                          rd_en,
  output logic [ADDR_W-1:0]             rd_addr,
  input  logic [element_width*NI-1:0]   first_row_data,
  input  logic [element_width*NI-1:0]   second_row_data,
  output logic [element_width*NI-1:0]   first_row_input,
  output logic [element_width*NI-1:0]   second_row_input,
  output logic [element_width-1:0]      constant,
  output logic                          op,
  input  logic [element_width*NI-1:0]   result,
  output logic                          wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [element_width*NI-1:0]   wr_data,
  output logic                          busy,
  output logic                          finish
);

  localparam int unsigned CHUNKS = (NOE + NI - 1) / NI;
  localparam int unsigned DEPTH  = 2 + LAT;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(CHUNKS - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e            state;
  logic [DEPTH-1:0]  vld_pipe;
  logic [ADDR_W-1:0] addr_pipe [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= StIdle;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      busy     <= 1'b0;
      finish   <= 1'b0;
      constant <= '0;
      op       <= 1'b0;
    end else begin
      finish <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            constant <= constant_in;
            op       <= op_in;
            rd_addr  <= '0;
            rd_en    <= 1'b1;
            busy     <= 1'b1;
            state    <= StIssue;
          end
        end
        StIssue: begin
          if (rd_addr == LastAddr) begin
            rd_en <= 1'b0;
            state <= StDrain;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        StDrain: begin
          // Finish is raised the cycle after the final chunk is written.
          if (wr_en && (wr_addr == LastAddr)) begin
            finish <= 1'b1;
            state  <= StDone;
          end
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Stage 0 marks the cycle memory data returns; the last stage lines up with the unit result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe         <= '0;
      first_row_input  <= '0;
      second_row_input <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_pipe[i] <= '0;
      end
    end else begin
      vld_pipe     <= {vld_pipe[DEPTH-2:0], rd_en};
      addr_pipe[0] <= rd_addr;
      for (int i = 1; i < DEPTH; i++) begin
        addr_pipe[i] <= addr_pipe[i-1];
      end
      if (vld_pipe[0]) begin
        first_row_input  <= first_row_data;
        second_row_input <= second_row_data;
      end
    end
  end

  assign wr_en   = vld_pipe[DEPTH-1];
  assign wr_addr = addr_pipe[DEPTH-1];

  always_comb begin
    wr_data = '0;
    if (wr_en) begin
      for (int unsigned j = 0; j < NI; j++) begin
        if ((32'(wr_addr) * NI + j) < NOE) begin
          wr_data[element_width*(NI-j)-1 -: element_width] =
            result[element_width*(NI-j)-1 -: element_width];
        end
      end
    end
  end

endmodule

// File: tb/tb_vxc_stream_ctrl.sv
// Bench for vxc_stream_ctrl: three instances (NOE 16/20/8, LAT 4/4/1) checked every cycle
// against a run-cycle model plus a few hand-computed literal values.
module tb_vxc_stream_ctrl;

  localparam int NI    = 8;
  localparam int W     = 32;
  localparam int DW    = W * NI;
  localparam int NINST = 3;

  logic          clk;
  logic          rst_n       [NINST];
  logic          start       [NINST];
  logic          op_in       [NINST];
  logic [W-1:0]  cin         [NINST];
  logic          rd_en       [NINST];
  logic [7:0]    rd_addr     [NINST];
  logic [DW-1:0] frd         [NINST];
  logic [DW-1:0] srd         [NINST];
  logic [DW-1:0] fri         [NINST];
  logic [DW-1:0] sri         [NINST];
  logic [W-1:0]  cst         [NINST];
  logic          op          [NINST];
  logic [DW-1:0] res         [NINST];
  logic          wr_en       [NINST];
  logic [7:0]    wr_addr     [NINST];
  logic [DW-1:0] wr_data     [NINST];
  logic          busy        [NINST];
  logic          finish      [NINST];
  logic [DW-1:0] upipe       [NINST][4];

  int            rc          [NINST];
  logic [W-1:0]  mc          [NINST];
  logic          mop         [NINST];
  int            n_err;
  int            n_checks;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    vxc_stream_ctrl #(
      .NOE          ((g == 1) ? 20 : ((g == 2) ? 8 : 16)),
      .NI           (8),
      .element_width(32),
      .LAT          ((g == 2) ? 1 : 4),
      .ADDR_W       (8)
    ) u_dut (
      .clk             (clk),
      .reset           (rst_n[g]),
      .start           (start[g]),
      .op_in           (op_in[g]),
      .constant_in     (cin[g]),
      .rd_en           (rd_en[g]),
      .rd_addr         (rd_addr[g]),
      .first_row_data  (frd[g]),
      .second_row_data (srd[g]),
      .first_row_input (fri[g]),
      .second_row_input(sri[g]),
      .constant        (cst[g]),
      .op              (op[g]),
      .result          (res[g]),
      .wr_en           (wr_en[g]),
      .wr_addr         (wr_addr[g]),
      .wr_data         (wr_data[g]),
      .busy            (busy[g]),
      .finish          (finish[g])
    );
  end

  function automatic int noe_of(input int i);
    return (i == 1) ? 20 : ((i == 2) ? 8 : 16);
  endfunction
  function automatic int lat_of(input int i);
    return (i == 2) ? 1 : 4;
  endfunction
  function automatic int ch_of(input int i);
    return (noe_of(i) + NI - 1) / NI;
  endfunction
  function automatic int fin_of(input int i);
    return ch_of(i) + 3 + lat_of(i);
  endfunction

  // Element e of row A is 0x100+e, of row B is e+1 (padding positions included).
  function automatic logic [DW-1:0] chunk_row(input int row, input int k);
    logic [DW-1:0] r;
    for (int j = 0; j < NI; j++) begin
      r[W*(NI-j)-1 -: W] = (row != 0) ? W'(k * NI + j + 1) : W'(32'h100 + k * NI + j);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [W-1:0] c, input logic o);
    return o ? (a - c * b) : (a + c * b);
  endfunction

  function automatic logic [DW-1:0] unit_f(input logic [DW-1:0] va, input logic [DW-1:0] vb,
                                           input logic [W-1:0] c, input logic o);
    logic [DW-1:0] r;
    for (int j = 0; j < NI; j++) begin
      r[W*(NI-j)-1 -: W] = alu(va[W*(NI-j)-1 -: W], vb[W*(NI-j)-1 -: W], c, o);
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] exp_wr(input int i, input int k, input logic [W-1:0] c,
                                           input logic o);
    logic [DW-1:0] r;
    r = unit_f(chunk_row(0, k), chunk_row(1, k), c, o);
    for (int j = 0; j < NI; j++) begin
      if (k * NI + j >= noe_of(i)) r[W*(NI-j)-1 -: W] = '0;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int i, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s inst=%0d t=%0t got=%h exp=%h", nm, i, $time, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Row memories (one-cycle read latency) and the arithmetic unit (LAT-cycle pipeline).
  always @(posedge clk) begin
    for (int i = 0; i < NINST; i++) begin
      if (rd_en[i]) begin
        frd[i] <= chunk_row(0, int'(rd_addr[i]));
        srd[i] <= chunk_row(1, int'(rd_addr[i]));
      end else begin
        frd[i] <= {NI{32'hDEADBEEF}};
        srd[i] <= {NI{32'hBAADF00D}};
      end
      upipe[i][0] <= unit_f(fri[i], sri[i], cst[i], op[i]);
      for (int s = 1; s < 4; s++) upipe[i][s] <= upipe[i][s-1];
    end
  end

  always_comb begin
    for (int i = 0; i < NINST; i++) res[i] = upipe[i][lat_of(i)-1];
  end

  // Run-cycle model: rc = cycles since the accepted start (0 = idle).
  always @(posedge clk) begin
    for (int i = 0; i < NINST; i++) begin
      if (!rst_n[i]) begin
        rc[i] <= 0;
      end else if (rc[i] == fin_of(i)) begin
        rc[i] <= 0;
      end else if (rc[i] > 0) begin
        rc[i] <= rc[i] + 1;
      end else if (start[i]) begin
        rc[i]  <= 1;
        mc[i]  <= cin[i];
        mop[i] <= op_in[i];
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NINST; i++) begin
      int c;
      int ch;
      int l;
      int f;
      c  = rc[i];
      ch = ch_of(i);
      l  = lat_of(i);
      f  = fin_of(i);
      if (!rst_n[i]) begin
        chk("rst_ctl", i, {rd_en[i], rd_addr[i], wr_en[i], wr_addr[i], busy[i], finish[i],
                           op[i], cst[i]}, '0);
        chk("rst_data", i, wr_data[i] | fri[i] | sri[i], '0);
      end else begin
        chk("busy", i, busy[i], (c >= 1) && (c <= f));
        chk("finish", i, finish[i], c == f);
        chk("rd_en", i, rd_en[i], (c >= 1) && (c <= ch));
        if ((c >= 1) && (c <= ch)) chk("rd_addr", i, rd_addr[i], DW'(c - 1));
        chk("wr_en", i, wr_en[i], (c >= l + 3) && (c <= ch + l + 2));
        if ((c >= l + 3) && (c <= ch + l + 2)) begin
          chk("wr_addr", i, wr_addr[i], DW'(c - l - 3));
          chk("wr_data", i, wr_data[i], exp_wr(i, c - l - 3, mc[i], mop[i]));
        end
        if ((c >= 3) && (c <= ch + 2)) begin
          chk("first_in", i, fri[i], chunk_row(0, c - 3));
          chk("second_in", i, sri[i], chunk_row(1, c - 3));
        end
        if (c >= 1) chk("const_op", i, {op[i], cst[i]}, {mop[i], mc[i]});
      end
    end
  end

  task automatic wait_finish(input int i);
    logic seen;
    int   n;
    seen = 1'b0;
    n    = 0;
    while (!seen && (n < 40)) begin
      @(posedge clk);
      #1;
      seen = finish[i];
      n++;
    end
    chk("finish_seen", i, seen, 1'b1);
  endtask

  initial begin
    n_err    = 0;
    n_checks = 0;
    for (int i = 0; i < NINST; i++) begin
      rst_n[i] = 1'b0;
      start[i] = 1'b0;
      op_in[i] = 1'b0;
      cin[i]   = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NINST; i++) rst_n[i] = 1'b1;
    @(posedge clk);
    #1;
    // cycle 0
    start[0] = 1'b1; op_in[0] = 1'b0; cin[0] = 32'h40000000;
    start[1] = 1'b1; op_in[1] = 1'b1; cin[1] = 32'd3;
    start[2] = 1'b1; op_in[2] = 1'b0; cin[2] = 32'd2;
    @(posedge clk);
    #1;
    for (int i = 0; i < NINST; i++) start[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // cycle 4: stray start on a busy instance
    start[0] = 1'b1; op_in[0] = 1'b1; cin[0] = 32'h12345678;
    chk("lit_lat1_wr_en", 2, wr_en[2], 1'b1);
    chk("lit_lat1_lane7", 2, wr_data[2][31:0], 32'h117);
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    chk("lit_lat1_finish", 2, finish[2], 1'b1);
    repeat (2) @(posedge clk);
    #1;
    // cycle 7
    chk("lit_c7_wr", 0, {wr_en[0], wr_addr[0]}, 9'h100);
    chk("lit_c7_lane0", 0, wr_data[0][255:224], 32'h40000100);
    repeat (2) @(posedge clk);
    #1;
    // cycle 9
    chk("lit_c9_finish", 0, finish[0], 1'b1);
    chk("lit_pad_wr", 1, {wr_en[1], wr_addr[1]}, 9'h102);
    chk("lit_pad_lane3", 1, wr_data[1][159:128], 32'hD7);
    chk("lit_pad_zero", 1, wr_data[1][127:0], '0);
    @(posedge clk);
    #1;
    // cycle 10: back-to-back start right after the finish cycle
    chk("lit_c10_finish", 1, finish[1], 1'b1);
    start[0] = 1'b1; op_in[0] = 1'b1; cin[0] = 32'h10;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    chk("lit_b2b_rd", 0, {rd_en[0], rd_addr[0]}, 9'h100);
    wait_finish(0);
    @(posedge clk);
    #1;
    start[0] = 1'b1; op_in[0] = 1'b0; cin[0] = 32'h40000000;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    // sixth cycle of the run: asynchronous abort
    rst_n[0] = 1'b0;
    #1;
    chk("async_rst_ctl", 0, {rd_en[0], wr_en[0], busy[0], finish[0], op[0], cst[0]}, '0);
    chk("async_rst_data", 0, wr_data[0] | fri[0] | sri[0], '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    start[0] = 1'b1; op_in[0] = 1'b1; cin[0] = 32'd5;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    wait_finish(0);
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
